vector_load_unit: RTL
=====================

// Module: vector_load_unit
// PURPOSE
//   Fills one vector register from memory: fetches REG_WIDTH/WORD_WIDTH consecutive words,
//   packs them into a REG_WIDTH vector and issues a single write to the vector register
//   file (drives its WE3/A3/WD3 write port). Sits upstream of the register file.
//   Issue and collect overlap, so a full load takes NWORDS+2 cycles with a 1-cycle memory.
// PARAMETERS
//   REG_WIDTH      256  vector register width, bits
//   WORD_WIDTH     32   memory word width; NWORDS = REG_WIDTH/WORD_WIDTH (default 8)
//   REG_ADDR_W     5    register index width (32 registers)
//   MEM_ADDR_W     32   byte address width
// PORTS
//   Interface: one clock; reset is asynchronous and active-low.
//   clk            in   1           clock, rising edge
//   rst            in   1           asynchronous, active-low reset
//   req_valid      in   1           load request
//   req_ready      out  1           unit idle and accepting
//   req_rd         in   REG_ADDR_W  destination vector register
//   req_base       in   MEM_ADDR_W  byte address of word 0
//   mem_req_valid  out  1           memory read request
//   mem_req_ready  in   1           memory accepts request
//   mem_addr       out  MEM_ADDR_W  byte address of current word
//   mem_rsp_valid  in   1           read data valid (in order, >=1 cycle after accept)
//   mem_rsp_data   in   WORD_WIDTH  read data
//   WE3            out  1           register file write enable (1-cycle pulse)
//   A3             out  REG_ADDR_W  register file write address
//   WD3            out  REG_WIDTH   register file write data
//   done           out  1           1-cycle pulse, same cycle as WE3
// BEHAVIOUR
//   - Reset (rst=0): state IDLE; issue/recv counters, outstanding count, data buffer = 0;
//     outputs mem_req_valid=0, mem_addr=0, WE3=0, A3=0, WD3=0, done=0; req_ready=1.
//   - Reset mid-load: load is abandoned, partial data is discarded, no WE3 is issued; late
//     responses after reset are ignored (recv counter is back at 0 and state is IDLE).
//   - FSM: IDLE -> FETCH on req_valid&&req_ready (latch rd, base; counters cleared).
//     FETCH -> WRITE when the NWORDS-th response is captured. WRITE -> IDLE after 1 cycle.
//   - req_ready = (state==IDLE); requests while busy are not accepted (held by producer).
//   - FETCH issue: mem_req_valid=1 while issue_cnt<NWORDS; mem_addr = base + issue_cnt*STRIDE;
//     issue_cnt increments on mem_req_valid&&mem_req_ready; valid/addr held stable until
//     accepted. Address arithmetic wraps modulo 2^MEM_ADDR_W.
//   - FETCH collect: on mem_rsp_valid with outstanding>0, word k=recv_cnt stored to
//     buf[k*WORD_WIDTH +: WORD_WIDTH]; word 0 lands in the LS bits. Accept and response in
//     the same cycle update outstanding by +1-1 = 0. mem_rsp_valid with outstanding==0
//     (incl. IDLE/WRITE) is ignored.
//   - WRITE: WE3=1, A3=latched rd, WD3=assembled vector, done=1 for exactly one cycle; A3/WD3
//     hold last values afterwards, WE3=0. Register 0 is written like any other register.
//   - Latency, mem_req_ready=1, 1-cycle response: accept at T, requests T+1..T+NWORDS,
//     last response T+NWORDS+1, WE3/done at T+NWORDS+2, req_ready again at T+NWORDS+3.
//   - Back-pressure (mem_req_ready=0) only stalls issue; collected words are not lost.
// CONFIGURATION
//   VLOAD_STRIDE_EN defined: extra input req_stride [MEM_ADDR_W-1:0] (signed byte stride),
//     latched with the request; word k address = base + k*stride (stride 0 = broadcast).
//   Not defined: port absent; STRIDE fixed at WORD_WIDTH/8 (4 bytes, unit-stride).
// TESTING
//   1. rst=0 mid-sim -> WE3=0, done=0, mem_req_valid=0, req_ready=1 while low and after.
//   2. Unit load rd=3, base=0x100, mem words 0x..7 -> addrs 0x100..0x11C, WE3 at T+10,
//      A3=3, WD3=0x00000007_00000006_..._00000000 (word0 in LS bits).
//   3. mem_req_ready low 3 cycles after 2nd request -> same WD3 as test 2, WE3 3 cycles late;
//      req_valid held during load -> not accepted until req_ready returns.
//   4. rst pulsed low after 4 responses, then new load rd=5 -> only one WE3 (A3=5),
//      no write to rd=3; stray mem_rsp_valid in IDLE -> no effect.
//   5. base=0xFFFFFFF8 -> addrs wrap to 0x00000000..0x00000014.
//   6. VLOAD_STRIDE_EN, stride=0x40 -> addrs base+0x40*k; stride=0 -> all addrs = base.

Source files
------------

// File: rtl/vector_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_load_unit
// Purpose  : Fills one vector register from memory. On an accepted request it
//            issues NWORDS = REG_WIDTH/WORD_WIDTH word reads at base, base+S,
//            base+2S, ... and packs the responses (word 0 in the LS bits). It
//            then drives a single one-cycle write on the register file port
//            WE3/A3/WD3. Request issue and response collection overlap.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_ready/req_rd/req_base  - load request handshake
//            req_stride                           - only with VLOAD_STRIDE_EN
//            mem_req_valid/mem_req_ready/mem_addr - memory read request
//            mem_rsp_valid/mem_rsp_data           - in-order read responses
//            WE3/A3/WD3                           - register file write port
//            done                                 - pulses together with WE3
// Config   : VLOAD_STRIDE_EN - adds req_stride (signed byte stride, latched
//            with the request). Undefined: fixed stride of WORD_WIDTH/8 bytes.
// Revision : 1.0 - initial release
// ============================================================================
module vector_load_unit #(
  parameter int REG_WIDTH  = 256,
  parameter int WORD_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic [MEM_ADDR_W-1:0] req_base,
`ifdef VLOAD_STRIDE_EN
  input  logic [MEM_ADDR_W-1:0] req_stride,
`endif
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [REG_WIDTH-1:0]  WD3,
  output logic                  done
);

  localparam int NWORDS = REG_WIDTH / WORD_WIDTH;
  // One extra bit so the counters can reach NWORDS itself.
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                state_q,       state_d;
  logic [CNT_W-1:0]      issue_cnt_q,   issue_cnt_d;
  logic [CNT_W-1:0]      recv_cnt_q,    recv_cnt_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [REG_WIDTH-1:0]  vbuf_q,        vbuf_d;
  logic [REG_ADDR_W-1:0] rd_q,          rd_d;
  logic [MEM_ADDR_W-1:0] base_q,        base_d;
  logic                  we3_q,         we3_d;
  logic [REG_ADDR_W-1:0] a3_q,          a3_d;
  logic [REG_WIDTH-1:0]  wd3_q,         wd3_d;
  logic                  done_q,        done_d;

  logic [MEM_ADDR_W-1:0] w_stride;
  logic                  w_issue_fire;
  logic                  w_rsp_fire;

`ifdef VLOAD_STRIDE_EN
  logic [MEM_ADDR_W-1:0] stride_q, stride_d;
  assign w_stride = stride_q;
`else
  localparam int STRIDE = WORD_WIDTH / 8;
  assign w_stride = MEM_ADDR_W'(STRIDE);
`endif

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_FETCH) && (issue_cnt_q < CNT_W'(NWORDS));
  // Address is a pure function of latched base and issue count, so it stays
  // stable while the memory back-pressures. Wraps modulo 2^MEM_ADDR_W; the
  // truncated product also handles negative (two's complement) strides.
  assign mem_addr      = base_q + (MEM_ADDR_W'(issue_cnt_q) * w_stride);

  assign w_issue_fire  = mem_req_valid && mem_req_ready;
  // Responses are only meaningful for requests this load actually issued;
  // anything else (idle, write cycle, leftovers from before a reset) is dropped.
  assign w_rsp_fire    = (state_q == S_FETCH) && mem_rsp_valid && (outstanding_q != '0);

  assign WE3  = we3_q;
  assign A3   = a3_q;
  assign WD3  = wd3_q;
  assign done = done_q;

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    outstanding_d = outstanding_q;
    vbuf_d        = vbuf_q;
    rd_d          = rd_q;
    base_d        = base_q;
`ifdef VLOAD_STRIDE_EN
    stride_d      = stride_q;
`endif
    we3_d         = 1'b0;
    done_d        = 1'b0;
    a3_d          = a3_q;
    wd3_d         = wd3_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d       = S_FETCH;
          rd_d          = req_rd;
          base_d        = req_base;
`ifdef VLOAD_STRIDE_EN
          stride_d      = req_stride;
`endif
          issue_cnt_d   = '0;
          recv_cnt_d    = '0;
          outstanding_d = '0;
          vbuf_d        = '0;
        end
      end

      S_FETCH: begin
        if (w_issue_fire) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        // Net change handles accept and response landing in the same cycle.
        outstanding_d = outstanding_q + CNT_W'(w_issue_fire) - CNT_W'(w_rsp_fire);
        if (w_rsp_fire) begin
          for (int k = 0; k < NWORDS; k++) begin
            if (recv_cnt_q == CNT_W'(k)) begin
              vbuf_d[k*WORD_WIDTH +: WORD_WIDTH] = mem_rsp_data;
            end
          end
          recv_cnt_d = recv_cnt_q + CNT_W'(1);
          // Last word: register the write now so WE3 lines up with S_WRITE.
          if (recv_cnt_q == CNT_W'(NWORDS - 1)) begin
            state_d = S_WRITE;
            we3_d   = 1'b1;
            done_d  = 1'b1;
            a3_d    = rd_q;
            wd3_d   = vbuf_d;
          end
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      outstanding_q <= '0;
      vbuf_q        <= '0;
      rd_q          <= '0;
      base_q        <= '0;
`ifdef VLOAD_STRIDE_EN
      stride_q      <= '0;
`endif
      we3_q         <= 1'b0;
      a3_q          <= '0;
      wd3_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      outstanding_q <= outstanding_d;
      vbuf_q        <= vbuf_d;
      rd_q          <= rd_d;
      base_q        <= base_d;
`ifdef VLOAD_STRIDE_EN
      stride_q      <= stride_d;
`endif
      we3_q         <= we3_d;
      a3_q          <= a3_d;
      wd3_q         <= wd3_d;
      done_q        <= done_d;
    end
  end

endmodule
`default_nettype wire
